// File: rtl/register_writeback.sv
// Register-file write port: arbitrates ALU vs buffered long-latency results; RAW scoreboard; optional forward (REGISTER_WB_BYPASS_EN).
// Latency: ALU accept -> wren +1 cycle; mem push -> wren +2 cycles minimum.
// Backpressure: alu_ready drops when the FIFO wins; mem_ready = !full.
module register_writeback #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_waddr,
    input  logic [31:0] alu_wdata,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        issue_valid,
    input  logic [4:0]  issue_waddr,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic        busy1,
    output logic        busy2,
    output logic        wren,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        byp_hit1,
    output logic        byp_hit2,
    output logic [31:0] byp_data1,
    output logic [31:0] byp_data2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;
    logic [31:0]   pending;
    logic [31:0]   pending_nxt;

    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        fifo_win;
    logic        alu_win;
    logic        sel_vld;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic        sel_wr;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign mem_ready  = !fifo_full;
    assign push       = mem_valid && !fifo_full;

    always_comb begin
        fifo_win = !fifo_empty && (!alu_valid || starve_cnt == STARVE_MAX);
        alu_win  = alu_valid && !fifo_win;
        sel_vld  = fifo_win || alu_win;
        sel_addr = fifo_win ? fifo_addr[rd_ptr] : alu_waddr;
        sel_data = fifo_win ? fifo_data[rd_ptr] : alu_wdata;
        // x0 results are consumed but never reach the write port
        sel_wr   = sel_vld && (sel_addr != 5'd0);
    end

    assign pop       = fifo_win;
    assign alu_ready = !fifo_win;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mem_waddr;
            fifo_data[wr_ptr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The ALU can only win against a non-empty FIFO when the counter is below the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (fifo_empty || fifo_win) begin
            starve_cnt <= '0;
        end else if (alu_win && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_comb begin
        pending_nxt = pending;
        if (fifo_win && sel_addr != 5'd0)
            pending_nxt[sel_addr] = 1'b0;
        // a new issue to the same register outranks the retiring write
        if (issue_valid && issue_waddr != 5'd0)
            pending_nxt[issue_waddr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    assign busy1 = pending[raddr1];
    assign busy2 = pending[raddr2];

    always_ff @(posedge clk) begin
        if (rst) begin
            wren  <= 1'b0;
            waddr <= 5'd0;
            wdata <= 32'd0;
        end else begin
            wren <= sel_wr;
            if (sel_wr) begin
                waddr <= sel_addr;
                wdata <= sel_data;
            end
        end
    end

`ifdef REGISTER_WB_BYPASS_EN
    assign byp_hit1  = wren && (waddr == raddr1);
    assign byp_hit2  = wren && (waddr == raddr2);
    assign byp_data1 = wdata;
    assign byp_data2 = wdata;
`else
    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_data1 = 32'd0;
    assign byp_data2 = 32'd0;
`endif

endmodule

// File: tb/tb_register_writeback.sv
// Bench for register_writeback: directed scenarios plus a randomized run against a queue-based model.
module tb_register_writeback;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;
`ifdef REGISTER_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        issue_valid;
    logic [4:0]  issue_waddr;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        busy1;
    logic        busy2;
    logic        wren;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;

    int n_tests = 0;
    int n_fail  = 0;

    register_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .issue_valid(issue_valid), .issue_waddr(issue_waddr),
        .raddr1(raddr1), .raddr2(raddr2), .busy1(busy1), .busy2(busy2),
        .wren(wren), .waddr(waddr), .wdata(wdata),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_waddr = 0; alu_wdata = 0;
        mem_valid = 0; mem_waddr = 0; mem_wdata = 0;
        issue_valid = 0; issue_waddr = 0; raddr1 = 0; raddr2 = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        alu_valid = 1; alu_waddr = 9; alu_wdata = 32'h1111;
        mem_valid = 1; mem_waddr = 4; mem_wdata = 32'h2222;
        issue_valid = 1; issue_waddr = 7; raddr1 = 7; raddr2 = 4;
        cyc(); cyc();
        n_tests++; if (wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b want 0", wren); end
        n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready got %b want 1", mem_ready); end
        n_tests++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b%b want 00", busy1, busy2); end
        n_tests++; if (byp_hit1 !== 1'b0 || byp_data1 !== 32'd0) begin n_fail++; $display("FAIL reset_byp got %b/%h want 0/0", byp_hit1, byp_data1); end
        rst = 0; idle();
        cyc();
        n_tests++; if (wren !== 1'b0) begin n_fail++; $display("FAIL post_reset_wren got %b want 0", wren); end
    endtask

    task automatic test_alu();
        alu_valid = 1; alu_waddr = 5; alu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_tests++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready got %b want 1", alu_ready); end
        cyc();
        alu_waddr = 0; alu_wdata = 32'h77;
        n_tests++;
        if (wren !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL alu_write got %b/%0d/%h want 1/5/deadbeef", wren, waddr, wdata);
        end
        cyc();
        alu_valid = 0;
        n_tests++; if (wren !== 1'b0) begin n_fail++; $display("FAIL alu_x0 got wren %b want 0", wren); end
        cyc();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1; issue_waddr = 7; raddr1 = 7; raddr2 = 8;
        cyc();
        issue_valid = 0;
        n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_set got %b want 1", busy1); end
        n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL sb_other got %b want 0", busy2); end
        mem_valid = 1; mem_waddr = 7; mem_wdata = 32'h12;
        cyc();
        mem_valid = 0;
        n_tests++; if (wren !== 1'b0 || busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_wait got wren %b busy %b want 0 1", wren, busy1); end
        cyc();
        n_tests++;
        if (wren !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h12) begin
            n_fail++; $display("FAIL sb_mem_write got %b/%0d/%h want 1/7/12", wren, waddr, wdata);
        end
        cyc();
        n_tests++; if (busy1 !== 1'b0 || wren !== 1'b0) begin n_fail++; $display("FAIL sb_clear got busy %b wren %b want 0 0", busy1, wren); end
        idle();
        cyc();
    endtask

    task automatic test_fifo_full();
        int idx;
        logic [4:0]  ea [4];
        logic [31:0] ed [4];
        ea = '{5'd19, 5'd21, 5'd22, 5'd23};
        ed = '{32'h1009, 32'hA1, 32'hA2, 32'hA3};
        for (int k = 0; k < 11; k++) begin
            idx = (k == 10) ? 9 : k;
            alu_valid = 1; alu_waddr = 5'(10 + idx); alu_wdata = 32'h1000 + 32'(idx);
            mem_valid = (k < 4); mem_waddr = 5'(20 + k); mem_wdata = 32'hA0 + 32'(k);
            @(negedge clk);
            n_tests++; if (alu_ready !== (k != 9)) begin n_fail++; $display("FAIL full_alu_ready k=%0d got %b want %b", k, alu_ready, k != 9); end
            n_tests++; if (mem_ready !== (k < 4 || k == 10)) begin n_fail++; $display("FAIL full_mem_ready k=%0d got %b want %b", k, mem_ready, k < 4 || k == 10); end
            n_tests++;
            if (k == 0) begin
                if (wren !== 1'b0) begin n_fail++; $display("FAIL full_wren k=0 got %b want 0", wren); end
            end else if (k < 10) begin
                if (wren !== 1'b1 || waddr !== 5'(9 + k) || wdata !== 32'h1000 + 32'(k - 1)) begin
                    n_fail++; $display("FAIL full_alu_wr k=%0d got %b/%0d/%h want 1/%0d/%h", k, wren, waddr, wdata, 9 + k, 32'h1000 + 32'(k - 1));
                end
            end else begin
                if (wren !== 1'b1 || waddr !== 5'd20 || wdata !== 32'hA0) begin
                    n_fail++; $display("FAIL full_fifo_wr got %b/%0d/%h want 1/20/a0", wren, waddr, wdata);
                end
            end
            cyc();
        end
        idle();
        for (int j = 0; j < 5; j++) begin
            n_tests++;
            if (j < 4) begin
                if (wren !== 1'b1 || waddr !== ea[j] || wdata !== ed[j]) begin
                    n_fail++; $display("FAIL drain j=%0d got %b/%0d/%h want 1/%0d/%h", j, wren, waddr, wdata, ea[j], ed[j]);
                end
            end else if (wren !== 1'b0) begin
                n_fail++; $display("FAIL drain_end got %b want 0", wren);
            end
            cyc();
        end
    endtask

    task automatic test_x0();
        mem_valid = 1; mem_waddr = 0; mem_wdata = 32'hBAD;
        cyc();
        mem_waddr = 12; mem_wdata = 32'h1234;
        cyc();
        mem_valid = 0;
        n_tests++; if (wren !== 1'b0) begin n_fail++; $display("FAIL x0_suppressed got %b want 0", wren); end
        cyc();
        n_tests++;
        if (wren !== 1'b1 || waddr !== 5'd12 || wdata !== 32'h1234) begin
            n_fail++; $display("FAIL x0_next got %b/%0d/%h want 1/12/1234", wren, waddr, wdata);
        end
        cyc();
        n_tests++; if (wren !== 1'b0 || mem_ready !== 1'b1) begin n_fail++; $display("FAIL x0_empty got wren %b ready %b want 0 1", wren, mem_ready); end
    endtask

    task automatic test_bypass();
        alu_valid = 1; alu_waddr = 3; alu_wdata = 32'h55;
        cyc();
        idle();
        raddr1 = 4; raddr2 = 3;
        #1;
        n_tests++; if (byp_hit2 !== BYP) begin n_fail++; $display("FAIL byp_hit2 got %b want %b", byp_hit2, BYP); end
        n_tests++; if (byp_data2 !== (BYP ? 32'h55 : 32'h0)) begin n_fail++; $display("FAIL byp_data2 got %h want %h", byp_data2, BYP ? 32'h55 : 32'h0); end
        n_tests++; if (byp_hit1 !== 1'b0) begin n_fail++; $display("FAIL byp_hit1 got %b want 0", byp_hit1); end
        cyc();
    endtask

    task automatic test_random();
        logic [36:0] q[$];
        bit          pend [32];
        int          starve;
        bit          m_wren;
        logic [4:0]  m_waddr;
        logic [31:0] m_wdata;
        bit          hold_alu;
        bit          e_mem_ready, e_fifo_win, e_alu_win, had_entries, sel_v, e_hit1, e_hit2;
        logic [36:0] e;
        logic [4:0]  sa;
        logic [31:0] sd;
        rst = 1; idle();
        cyc();
        rst = 0;
        q.delete();
        foreach (pend[i]) pend[i] = 0;
        starve = 0; m_wren = 0; m_waddr = 0; m_wdata = 0; hold_alu = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            if (!hold_alu) begin
                alu_valid = ($urandom_range(0, 9) < 6);
                alu_waddr = 5'($urandom_range(0, 7));
                alu_wdata = $urandom;
            end
            mem_valid   = ($urandom_range(0, 9) < 4);
            mem_waddr   = 5'($urandom_range(0, 7));
            mem_wdata   = $urandom;
            issue_valid = ($urandom_range(0, 9) < 3);
            issue_waddr = 5'($urandom_range(0, 7));
            raddr1      = 5'($urandom_range(0, 7));
            raddr2      = 5'($urandom_range(0, 7));
            @(negedge clk);
            had_entries = (q.size() != 0);
            e_mem_ready = (q.size() < DEPTH);
            e_fifo_win  = had_entries && (!alu_valid || starve == STARVE_LIMIT);
            e_alu_win   = alu_valid && !e_fifo_win;
            e_hit1      = BYP && m_wren && (m_waddr == raddr1);
            e_hit2      = BYP && m_wren && (m_waddr == raddr2);
            n_tests++; if (alu_ready !== !e_fifo_win) begin n_fail++; $display("FAIL rnd_alu_ready c=%0d got %b want %b", c, alu_ready, !e_fifo_win); end
            n_tests++; if (mem_ready !== e_mem_ready) begin n_fail++; $display("FAIL rnd_mem_ready c=%0d got %b want %b", c, mem_ready, e_mem_ready); end
            n_tests++; if (busy1 !== pend[raddr1] || busy2 !== pend[raddr2]) begin
                n_fail++; $display("FAIL rnd_busy c=%0d got %b%b want %b%b", c, busy1, busy2, pend[raddr1], pend[raddr2]);
            end
            n_tests++; if (wren !== m_wren) begin n_fail++; $display("FAIL rnd_wren c=%0d got %b want %b", c, wren, m_wren); end
            if (m_wren) begin
                n_tests++; if (waddr !== m_waddr || wdata !== m_wdata) begin
                    n_fail++; $display("FAIL rnd_wpayload c=%0d got %0d/%h want %0d/%h", c, waddr, wdata, m_waddr, m_wdata);
                end
            end
            n_tests++; if (byp_hit1 !== e_hit1 || byp_hit2 !== e_hit2) begin
                n_fail++; $display("FAIL rnd_byp_hit c=%0d got %b%b want %b%b", c, byp_hit1, byp_hit2, e_hit1, e_hit2);
            end
            if (e_hit1 || !BYP) begin
                n_tests++; if (byp_data1 !== (BYP ? m_wdata : 32'd0)) begin
                    n_fail++; $display("FAIL rnd_byp_data1 c=%0d got %h want %h", c, byp_data1, BYP ? m_wdata : 32'd0);
                end
            end
            if (rst) begin
                q.delete();
                foreach (pend[i]) pend[i] = 0;
                starve = 0; m_wren = 0; m_waddr = 0; m_wdata = 0; hold_alu = 0;
            end else begin
                sel_v = 0; sa = 0; sd = 0;
                if (e_fifo_win) begin
                    e = q.pop_front();
                    sa = e[36:32]; sd = e[31:0]; sel_v = 1;
                    if (sa != 0) pend[sa] = 0;
                end else if (e_alu_win) begin
                    sa = alu_waddr; sd = alu_wdata; sel_v = 1;
                end
                if (issue_valid && issue_waddr != 0) pend[issue_waddr] = 1;
                if (!had_entries || e_fifo_win) starve = 0;
                else if (starve < STARVE_LIMIT) starve++;
                if (mem_valid && e_mem_ready) q.push_back({mem_waddr, mem_wdata});
                m_wren = sel_v && (sa != 0);
                if (m_wren) begin m_waddr = sa; m_wdata = sd; end
                hold_alu = alu_valid && !e_alu_win;
            end
            @(posedge clk);
            #1;
        end
        rst = 0; idle();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_alu();
        test_scoreboard();
        test_fifo_full();
        test_x0();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
